// File: rtl/rv_unit_arbiter_if.sv
// rv_unit_arbiter_if: client request/response ports, compute-unit pins and status of the arbiter.
interface rv_unit_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int RESP_W  = 32
);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [RESP_W-1:0]         rsp_data;
   logic                      unit_valid_in;
   logic                      unit_ready_out;
   logic [DATA_W-1:0]         unit_data_in;
   logic                      unit_valid_out;
   logic                      unit_ready_in;
   logic [RESP_W-1:0]         unit_data_out;
   logic [IW-1:0]             owner;
   logic                      busy;
   logic                      timeout_err;
   modport master (
      output req_valid, req_data, rsp_ready, unit_ready_out, unit_valid_out, unit_data_out,
      input  req_ready, rsp_valid, rsp_data, unit_valid_in, unit_data_in, unit_ready_in,
             owner, busy, timeout_err
   );
   modport slave (
      input  req_valid, req_data, rsp_ready, unit_ready_out, unit_valid_out, unit_data_out,
      output req_ready, rsp_valid, rsp_data, unit_valid_in, unit_data_in, unit_ready_in,
             owner, busy, timeout_err
   );
endinterface

// File: rtl/rv_unit_arbiter.sv
// rv_unit_arbiter: round-robin sharing of one non-pipelined ready-valid compute unit among NUM_REQ clients.
module rv_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int RESP_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic             clk,
   input logic             reset,
   rv_unit_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {ARB, ISSUE, WAIT} state_t;
   state_t        state, state_n;
   logic [IW-1:0] rr_ptr, owner_r, grant;
   logic [TW-1:0] timer;
   logic          err, rsp_fire;
   assign rsp_fire = bus.unit_valid_out && bus.rsp_ready[owner_r];
   // Scan downward so the last hit is the first valid requester at or after rr_ptr.
   always_comb begin
      grant = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req_valid[IW'((int'(rr_ptr) + k) % NUM_REQ)])
            grant = IW'((int'(rr_ptr) + k) % NUM_REQ);
   end
   always_comb begin
      state_n = (state == ARB && |bus.req_valid) ? ISSUE :
                (state == ISSUE && bus.unit_ready_out) ? WAIT :
                (state == WAIT && rsp_fire) ? ARB : state;
      bus.req_ready     = (state == ISSUE) ? NUM_REQ'(bus.unit_ready_out) << owner_r : '0;
      bus.unit_valid_in = state == ISSUE;
      bus.unit_data_in  = bus.req_data[owner_r*DATA_W +: DATA_W];
      bus.rsp_valid     = (state == WAIT) ? NUM_REQ'(bus.unit_valid_out) << owner_r : '0;
      bus.rsp_data      = bus.unit_data_out;
      bus.unit_ready_in = state == WAIT && bus.rsp_ready[owner_r];
      bus.owner         = owner_r;
      bus.busy          = state != ARB;
      bus.timeout_err   = err;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ARB;
         rr_ptr  <= '0;
         owner_r <= '0;
         timer   <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ARB && |bus.req_valid)
            owner_r <= grant;
         if (state == WAIT && rsp_fire)
            rr_ptr <= (owner_r == IW'(NUM_REQ - 1)) ? '0 : owner_r + 1'b1;
         timer <= (state == ARB) ? '0 : (timer < TW'(TIMEOUT)) ? timer + 1'b1 : timer;
         // Flag is raised as the timer steps onto TIMEOUT; the transaction keeps running.
         if (TIMEOUT > 0 && state != ARB && timer >= TW'(TIMEOUT - 1))
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rv_unit_arbiter.sv
// tb_rv_unit_arbiter: directed stimulus with a response scoreboard, behavioural compute unit and client models.
module tb_rv_unit_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int RW = 32;
   localparam int TO = 8;
   typedef struct {int idx; logic [RW-1:0] data;} exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   rv_unit_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .RESP_W(RW)) bus ();
   rv_unit_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RESP_W(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t e_mon;
   int issued[N];
   int done[N];
   logic [DW-1:0] base[N];
   logic [N-1:0] rsp_rdy;
   int lat = 3;
   logic bubble_chk = 1'b0;
   // Client i offers base[i]+done[i] while it has unissued transactions left.
   for (genvar g = 0; g < N; g++) begin : g_req
      assign bus.req_valid[g] = issued[g] != done[g];
      assign bus.req_data[g*DW +: DW] = base[g] + DW'(done[g]);
   end
   assign bus.rsp_ready = rsp_rdy;
   always @(posedge clk)
      for (int i = 0; i < N; i++)
         if (bus.req_valid[i] && bus.req_ready[i]) done[i] <= done[i] + 1;
   // Unit: accepts when idle, returns payload+0x10 after lat cycles.
   logic u_busy = 1'b0;
   logic u_v = 1'b0;
   int u_cnt = 0;
   logic [RW-1:0] u_res = '0;
   assign bus.unit_ready_out = !u_busy;
   assign bus.unit_valid_out = u_v;
   assign bus.unit_data_out  = u_res;
   always @(posedge clk)
      if (reset) begin
         u_busy <= 1'b0;
         u_v <= 1'b0;
      end else if (!u_busy) begin
         if (bus.unit_valid_in) begin
            u_busy <= 1'b1;
            u_cnt <= lat - 1;
            u_res <= RW'(bus.unit_data_in) + 32'h10;
         end
      end else if (!u_v) begin
         if (u_cnt == 0) u_v <= 1'b1;
         else u_cnt <= u_cnt - 1;
      end else if (bus.unit_ready_in) begin
         u_v <= 1'b0;
         u_busy <= 1'b0;
      end
   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask
   int cyc = 0;
   int last_fire = -1;
   logic prev_uvi = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (bus.rsp_valid != '0) chk("rsp_onehot", 64'($onehot(bus.rsp_valid)), 1);
      if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid %0b, expected none", bus.rsp_valid);
         end else begin
            e_mon = sb.pop_front();
            chk("rsp_owner", 64'(bus.rsp_valid & bus.rsp_ready), 64'(N'(1) << e_mon.idx));
            chk("rsp_data", 64'(bus.rsp_data), 64'(e_mon.data));
         end
         if (bubble_chk) last_fire = cyc;
      end
      if (bubble_chk && bus.unit_valid_in && !prev_uvi && last_fire >= 0)
         chk("bubble", 64'(cyc - last_fire), 2);
      prev_uvi = bus.unit_valid_in;
   end
   task automatic req(int i, int n, logic [DW-1:0] p);
      base[i] = p - DW'(done[i]);
      issued[i] = done[i] + n;
   endtask
   task automatic push(int i, logic [RW-1:0] d);
      exp_t e;
      e.idx = i;
      e.data = d;
      sb.push_back(e);
   endtask
   function automatic bit pending();
      for (int i = 0; i < N; i++) if (issued[i] != done[i]) return 1'b1;
      return 1'b0;
   endfunction
   task automatic wait_done(string name, int max);
      int k = 0;
      while ((sb.size() != 0 || pending()) && k < max) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(sb.size() == 0 && !pending()), 1);
   endtask
   task automatic do_reset(int n);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask
   initial begin
      int k;
      rsp_rdy = '1;
      for (int i = 0; i < N; i++) begin
         base[i] = '0;
         issued[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_owner", 64'(bus.owner), 0);
      chk("rst_err", 64'(bus.timeout_err), 0);
      chk("rst_req_ready", 64'(bus.req_ready), 0);
      chk("rst_uvi", 64'(bus.unit_valid_in), 0);
      chk("rst_uri", 64'(bus.unit_ready_in), 0);
      // Single request from client 2
      @(posedge clk);
      #1 push(2, 32'hBEEF);
      req(2, 1, 32'hBEDF);
      @(negedge clk);
      chk("t1_arb_cycle", 64'(bus.unit_valid_in), 0);
      @(negedge clk);
      chk("t1_uvi", 64'(bus.unit_valid_in), 1);
      chk("t1_owner", 64'(bus.owner), 2);
      chk("t1_udata", 64'(bus.unit_data_in), 64'h0000BEDF);
      chk("t1_req_ready", 64'(bus.req_ready), 64'b0100);
      wait_done("t1_done", 40);
      // Contention: all clients requesting out of reset
      @(posedge clk);
      #1 reset = 1'b1;
      lat = 3;
      req(0, 2, 32'hA000_0000);
      req(1, 1, 32'hA100_0000);
      req(2, 1, 32'hA200_0000);
      req(3, 1, 32'hA300_0000);
      push(0, 32'hA000_0010);
      push(1, 32'hA100_0010);
      push(2, 32'hA200_0010);
      push(3, 32'hA300_0010);
      push(0, 32'hA000_0011);
      bubble_chk = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      wait_done("t2_done", 100);
      bubble_chk = 1'b0;
      // Response backpressure on client 1
      @(posedge clk);
      #1 lat = 2;
      rsp_rdy[1] = 1'b0;
      req(1, 1, 32'h1234);
      push(1, 32'h1244);
      k = 0;
      while (!bus.rsp_valid[1] && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("t3_rsp_seen", 64'(bus.rsp_valid[1]), 1);
      for (int c = 0; c < 5; c++) begin
         chk("t3_hold_uri", 64'(bus.unit_ready_in), 0);
         chk("t3_hold_valid", 64'(bus.rsp_valid[1]), 1);
         chk("t3_hold_busy", 64'(bus.busy), 1);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_rdy[1] = 1'b1;
      @(negedge clk);
      chk("t3_release_uri", 64'(bus.unit_ready_in), 1);
      wait_done("t3_done", 20);
      // Pointer wrap after owner 3
      @(posedge clk);
      #1 lat = 3;
      req(3, 1, 32'h3000);
      push(3, 32'h3010);
      push(0, 32'h0010);
      push(1, 32'h1010);
      k = 0;
      while (!(bus.busy && bus.owner == 2'd3) && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("t4_grant3", 64'(bus.owner), 3);
      @(posedge clk);
      #1 req(0, 1, 32'h0000);
      req(1, 1, 32'h1000);
      wait_done("t4_done", 60);
      // Timeout with a slow unit
      do_reset(2);
      lat = 20;
      req(2, 1, 32'h5000);
      push(2, 32'h5010);
      k = 0;
      while (!bus.unit_valid_in && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("t5_issue", 64'(bus.unit_valid_in), 1);
      chk("t5_err_c1", 64'(bus.timeout_err), 0);
      repeat (5) @(negedge clk);
      chk("t5_err_c6", 64'(bus.timeout_err), 0);
      repeat (4) @(negedge clk);
      chk("t5_err_c10", 64'(bus.timeout_err), 1);
      wait_done("t5_done", 80);
      @(negedge clk);
      chk("t5_err_sticky", 64'(bus.timeout_err), 1);
      // Reset while waiting on the unit
      @(posedge clk);
      #1 lat = 10;
      req(3, 1, 32'h6000);
      k = 0;
      while (!(bus.busy && !bus.unit_valid_in) && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("t6_in_wait", 64'(bus.busy && !bus.unit_valid_in), 1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_busy", 64'(bus.busy), 0);
      chk("t6_err", 64'(bus.timeout_err), 0);
      chk("t6_owner", 64'(bus.owner), 0);
      chk("t6_req_ready", 64'(bus.req_ready), 0);
      chk("t6_rsp_valid", 64'(bus.rsp_valid), 0);
      chk("t6_uvi", 64'(bus.unit_valid_in), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      lat = 2;
      req(3, 1, 32'h7300);
      req(2, 1, 32'h7200);
      req(0, 1, 32'h7000);
      push(0, 32'h7010);
      push(2, 32'h7210);
      push(3, 32'h7310);
      wait_done("t6_done", 60);
      chk("t6_err_clear", 64'(bus.timeout_err), 0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
      $fatal(1);
   end
endmodule
